coo_row_sequencer: RTL and testbench

//  Producer side of the row-completion count interface in the GCN datapath.

---
 rtl/coo_row_sequencer.sv | 147 ++++++++++++++
 tb/tb_coo_row_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coo_row_sequencer.sv
// coo_row_sequencer: walks a row-sorted COO edge list and issues entries,
// pulsing row_done once per node row (empty rows included).
module coo_row_sequencer #(
   parameter int NUM_NODES = 6,
   parameter int ROW_W     = 3,
   parameter int VAL_W     = 8,
   parameter int ADDR_W    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_W:0]            nnz,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [2*ROW_W+VAL_W-1:0]   mem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ROW_W-1:0]           out_row,
   output logic [ROW_W-1:0]           out_col,
   output logic [VAL_W-1:0]           out_val,
   output logic                       row_done,
   output logic                       all_done,
   output logic                       busy,
   output logic                       err
);

   localparam int ENT_W = 2*ROW_W + VAL_W;
   localparam logic [ROW_W:0]  LAST_ROW = (ROW_W+1)'(NUM_NODES - 1);
   localparam logic [ROW_W:0]  N_ROWS   = (ROW_W+1)'(NUM_NODES);
   localparam logic [ROW_W:0]  ROW_ONE  = (ROW_W+1)'(1);
   localparam logic [ADDR_W:0] MAX_NNZ  = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_CHECK,
      S_GAP, S_ISSUE, S_TAIL, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   nnz_q, nnz_d;
   logic [ROW_W:0]    cur_q, cur_d;
   logic [ENT_W-1:0]  ent_q, ent_d;
   logic              err_q, err_d;

   logic [ADDR_W:0]   nnz_clamp;
   logic [ADDR_W:0]   idx_inc;
   logic [ROW_W:0]    cur_inc;
   logic [ROW_W:0]    e_row;

   assign nnz_clamp = (nnz > MAX_NNZ) ? MAX_NNZ : nnz;
   assign idx_inc   = idx_q + IDX_ONE;
   assign cur_inc   = cur_q + ROW_ONE;
   assign e_row     = {1'b0, ent_q[ENT_W-1 -: ROW_W]};

   assign mem_addr = idx_q[ADDR_W-1:0];
   assign busy     = (state_q != S_IDLE);
   assign err      = err_q;
   assign out_row  = out_valid ? ent_q[ENT_W-1 -: ROW_W] : '0;
   assign out_col  = out_valid ? ent_q[VAL_W +: ROW_W] : '0;
   assign out_val  = out_valid ? ent_q[VAL_W-1:0] : '0;

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         nnz_q   <= '0;
         cur_q   <= '0;
         ent_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         nnz_q   <= nnz_d;
         cur_q   <= cur_d;
         ent_q   <= ent_d;
         err_q   <= err_d;
      end
   end

   // next-state and output decode
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      nnz_d     = nnz_q;
      cur_d     = cur_q;
      ent_d     = ent_q;
      err_d     = err_q;
      mem_rd_en = 1'b0;
      out_valid = 1'b0;
      row_done  = 1'b0;
      all_done  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               nnz_d   = nnz_clamp;
               err_d   = 1'b0;
               idx_d   = '0;
               cur_d   = '0;
               state_d = (nnz_clamp != '0) ? S_READ : S_TAIL;
            end
         end
         S_READ: begin
            mem_rd_en = 1'b1;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            ent_d   = mem_rdata;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (e_row >= N_ROWS || e_row < cur_q) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (e_row > cur_q) begin
               state_d = S_GAP;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_GAP: begin
            row_done = 1'b1;
            cur_d    = cur_inc;
            if (cur_inc == e_row) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               idx_d   = idx_inc;
               state_d = (idx_inc < nnz_q) ? S_READ : S_TAIL;
            end
         end
         S_TAIL: begin
            row_done = 1'b1;
            cur_d    = cur_inc;
            if (cur_q >= LAST_ROW) state_d = S_DONE;
         end
         S_DONE: begin
            all_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_coo_row_sequencer.sv
// tb_coo_row_sequencer: table vectors, hand sequences and random runs
// checked against an event-trace reference model.
module tb_coo_row_sequencer;

   localparam int NN = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  nnz = '0;
   logic        mem_rd_en;
   logic [3:0]  mem_addr;
   logic [13:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  out_row, out_col;
   logic [7:0]  out_val;
   logic        row_done, all_done, busy, err;

   coo_row_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .nnz(nnz),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_val(out_val),
      .row_done(row_done), .all_done(all_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   logic [13:0] mem [16];
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   logic [23:0] outs;
   assign outs = {mem_rd_en, mem_addr, out_valid, out_row, out_col,
                  out_val, row_done, all_done, busy, err};

   int errors = 0;
   int checks = 0;
   int rdy_mode = 0;

   logic [31:0] obs[$];
   logic [31:0] exp_q[$];
   int pulse_cnt = 0;
   int alldone_cnt = 0;
   bit m_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   // consumer ready driver
   initial forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   // event monitor: issued entries and row pulses in order
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (start && !busy) begin
            obs.delete();
            pulse_cnt = 0;
            alldone_cnt = 0;
         end
         if (out_valid && out_ready)
            obs.push_back(32'h1000_0000 | 32'({out_row, out_col, out_val}));
         if (row_done) begin
            obs.push_back(32'h2000_0000 | 32'(pulse_cnt));
            pulse_cnt++;
         end
         if (all_done) alldone_cnt++;
      end
   end

   // reference: rows walked with plain arithmetic
   task automatic build_exp(input int n);
      int nn, cur, e;
      exp_q.delete();
      m_err = 1'b0;
      nn = (n > 16) ? 16 : n;
      cur = 0;
      for (int k = 0; k < nn; k++) begin
         e = int'(mem[k][13:11]);
         if (e >= NN || e < cur) begin
            m_err = 1'b1;
            break;
         end
         while (cur < e) begin
            exp_q.push_back(32'h2000_0000 | 32'(cur));
            cur++;
         end
         exp_q.push_back(32'h1000_0000 | 32'(mem[k]));
      end
      if (!m_err)
         while (cur < NN) begin
            exp_q.push_back(32'h2000_0000 | 32'(cur));
            cur++;
         end
   endtask

   function automatic int n_issues();
      int c = 0;
      foreach (obs[i]) if (obs[i][31:28] == 4'h1) c++;
      return c;
   endfunction

   task automatic start_run(input int n);
      build_exp(n);
      @(posedge clk); #1;
      nnz = 5'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_run(input bit poke);
      int cyc = 0;
      int sz;
      logic [31:0] a, w;
      while (alldone_cnt == 0 && cyc < 400) begin
         @(negedge clk); #1;
         start = 1'b0;
         cyc++;
         if (cyc == 1) chk("err_clear", 32'(err), 0);
         if (poke && cyc == 5 && busy && !all_done) begin
            nnz = 5'd0;
            start = 1'b1;
         end
      end
      start = 1'b0;
      chk("done_seen", 32'(alldone_cnt != 0), 1);
      @(negedge clk); #1;
      chk("busy_low", 32'(busy), 0);
      chk("alldone_once", 32'(alldone_cnt), 1);
      chk("err_flag", 32'(err), 32'(m_err));
      chk("trace_len", 32'(obs.size()), 32'(exp_q.size()));
      sz = (obs.size() > exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < sz; i++) begin
         a = (i < obs.size()) ? obs[i] : 32'hffff_ffff;
         w = (i < exp_q.size()) ? exp_q[i] : 32'hffff_ffff;
         chk("trace", a, w);
      end
   endtask

   typedef struct {
      int nnz;
      int rows[6];
      int exp_issue;
      int exp_pulse;
      bit exp_err;
   } vec_t;

   vec_t tbl[8];

   task automatic load_rows(input int rows[6]);
      for (int k = 0; k < 16; k++)
         mem[k] = (k < 6) ? {3'(rows[k]), 3'(k), 8'(16 + k)} : 14'h0;
   endtask

   initial begin
      int w;
      int r, row;
      tbl[0] = '{0, '{0, 0, 0, 0, 0, 0}, 0, 6, 1'b0};
      tbl[1] = '{5, '{0, 0, 1, 3, 5, 0}, 5, 6, 1'b0};
      tbl[2] = '{2, '{2, 1, 0, 0, 0, 0}, 1, 2, 1'b1};
      tbl[3] = '{1, '{6, 0, 0, 0, 0, 0}, 0, 0, 1'b1};
      tbl[4] = '{6, '{0, 1, 2, 3, 4, 5}, 6, 6, 1'b0};
      tbl[5] = '{3, '{5, 5, 5, 0, 0, 0}, 3, 6, 1'b0};
      tbl[6] = '{2, '{1, 0, 0, 0, 0, 0}, 1, 1, 1'b1};
      tbl[7] = '{1, '{7, 0, 0, 0, 0, 0}, 0, 0, 1'b1};
      for (int k = 0; k < 16; k++) mem[k] = '0;

      repeat (2) @(negedge clk);
      #1 chk("reset_outs", 32'(outs), 0);
      @(negedge clk); #1 reset = 1'b0;

      // nnz=0: pulses on cycles 1..6, all_done on 7
      rdy_mode = 0;
      start_run(0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         chk("t1_row_done", 32'(row_done), 32'(c <= 6));
         chk("t1_all_done", 32'(all_done), 32'(c == 7));
         chk("t1_out_valid", 32'(out_valid), 0);
      end
      finish_run(1'b0);

      // table vectors
      for (int i = 0; i < 8; i++) begin
         load_rows(tbl[i].rows);
         start_run(tbl[i].nnz);
         finish_run(1'b0);
         chk("tbl_issues", 32'(n_issues()), 32'(tbl[i].exp_issue));
         chk("tbl_pulses", 32'(pulse_cnt), 32'(tbl[i].exp_pulse));
         chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
      end

      // stall on entry 1 for four cycles
      load_rows(tbl[1].rows);
      @(posedge clk); #1;
      rdy_mode = 2;
      out_ready = 1'b0;
      start_run(5);
      w = 0;
      do begin @(negedge clk); #1; w++; end
      while (!out_valid && w < 20);
      chk("stall_v0", 32'(out_valid), 1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      w = 0;
      do begin @(negedge clk); #1; w++; end
      while (!out_valid && w < 20);
      for (int j = 0; j < 4; j++) begin
         if (j > 0) begin @(negedge clk); #1; end
         chk("stall_hold", 32'({out_valid, out_row, out_col, out_val}),
             32'({1'b1, 3'd0, 3'd1, 8'h11}));
         chk("stall_idx", 32'({mem_rd_en, mem_addr}), 32'({1'b0, 4'd1}));
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      rdy_mode = 0;
      out_ready = 1'b1;
      @(negedge clk); #1;
      chk("stall_adv", 32'({mem_rd_en, mem_addr, out_valid}),
          32'({1'b1, 4'd2, 1'b0}));
      finish_run(1'b0);

      // reset in the middle of a gap
      start_run(5);
      w = 0;
      do begin @(negedge clk); #1; w++; end
      while (!(row_done && busy) && w < 50);
      chk("gap_reached", 32'(row_done), 1);
      reset = 1'b1;
      #1 chk("midrun_reset_outs", 32'(outs), 0);
      @(negedge clk); #1 reset = 1'b0;
      start_run(5);
      finish_run(1'b0);
      chk("post_reset_pulses", 32'(pulse_cnt), 6);

      // random lists, random ready, occasional start while busy
      rdy_mode = 1;
      for (int t = 0; t < 30; t++) begin
         r = 0;
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) r++;
            row = r;
            if ($urandom_range(0, 11) == 0) row = int'($urandom_range(0, 7));
            mem[k] = {3'(row), 3'($urandom_range(0, 7)),
                      8'($urandom_range(0, 255))};
         end
         start_run(int'($urandom_range(0, 20)));
         finish_run(1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
